// File: rtl/tspp_types_pkg.sv
// Shared types for the TSPP front end: word type, fetch FSM states,
// the fetch/decode entry layout and the NOP used for fault entries.
package tspp_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  // addi x0, x0, 0 -- carries the misaligned-fetch fault down the pipe
  localparam word_t NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    word_t instr;
    word_t pc;
    logic  misaligned;
  } fd_entry_t;

  function automatic fd_entry_t fault_entry(input word_t addr);
    fault_entry = '{instr: NOP_INSTR, pc: addr, misaligned: 1'b1};
  endfunction

endpackage

// File: rtl/fetch_control_if.sv
// Control-to-fetch redirect/flush/stall bundle.
interface fetch_control_if;
  import tspp_types_pkg::*;

  logic  update_pc;
  word_t update_addr;
  logic  flush;
  logic  stall;

  modport fetch (input update_pc, update_addr, flush, stall);
  modport ctrl  (output update_pc, update_addr, flush, stall);

endinterface

// File: rtl/tspp_fetch_stage.sv
// Instruction fetch stage: sequential PC, redirect with drain of the
// in-flight request, one-entry skid under stall, misaligned-fetch fault.
module tspp_fetch_stage
  import tspp_types_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0200
) (
  input  logic                 CLK,
  input  logic                 RST,
  fetch_control_if.fetch       fc_if,
  output word_t                iaddr,
  output logic                 iren,
  input  logic                 ibusy,
  input  word_t                irdata,
  output logic                 fd_valid,
  output word_t                fd_instr,
  output word_t                fd_pc,
  output logic                 fd_misaligned,
  output logic [1:0]           dbg_state
);

  // Bus handshake: iren is the request valid, !ibusy is its ready; a
  // request completes (irdata valid) in any cycle with iren=1 and ibusy=0,
  // and iaddr is held stable for as long as ibusy=1.

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        req_q, req_d;
  fd_entry_t    fd_q, fd_d;
  logic         fd_valid_q, fd_valid_d;
  fd_entry_t    skid_q, skid_d;
  logic         skid_valid_q, skid_valid_d;

  fd_entry_t    cand;
  logic         cand_valid;
  logic         drop_skid;
  logic         upd_mis;
  word_t        target;

  assign iren          = (state_q == FETCH) || (state_q == DRAIN);
  assign iaddr         = req_q;
  assign fd_valid      = fd_valid_q;
  assign fd_instr      = fd_q.instr;
  assign fd_pc         = fd_q.pc;
  assign fd_misaligned = fd_q.misaligned;
  assign dbg_state     = state_q;

  assign upd_mis = fc_if.update_addr[1:0] != 2'b00;
  assign target  = fc_if.update_pc ? fc_if.update_addr : pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    cand       = '0;
    cand_valid = 1'b0;
    drop_skid  = 1'b0;

    case (state_q)
      FETCH: begin
        if (fc_if.update_pc) begin
          pc_d = fc_if.update_addr;
          if (ibusy) begin
            state_d = DRAIN;
          end else begin
            req_d = fc_if.update_addr;
            if (upd_mis) begin
              state_d    = FAULT;
              cand       = fault_entry(fc_if.update_addr);
              cand_valid = 1'b1;
            end
          end
        end else if (!ibusy) begin
          pc_d  = pc_q + 32'd4;
          req_d = req_q + 32'd4;
          if (!fc_if.flush) begin
            cand       = '{instr: irdata, pc: req_q, misaligned: 1'b0};
            cand_valid = 1'b1;
            if (fc_if.stall) state_d = HOLD;
          end
        end
      end

      DRAIN: begin
        // The in-flight word is dropped; the latest redirect target wins.
        pc_d = target;
        if (!ibusy) begin
          req_d = target;
          if (target[1:0] != 2'b00) begin
            state_d    = FAULT;
            cand       = fault_entry(target);
            cand_valid = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end

      HOLD, FAULT: begin
        if (fc_if.update_pc) begin
          pc_d      = fc_if.update_addr;
          req_d     = fc_if.update_addr;
          drop_skid = 1'b1;
          if (upd_mis) begin
            state_d    = FAULT;
            cand       = fault_entry(fc_if.update_addr);
            cand_valid = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end else begin
          cand       = skid_q;
          cand_valid = skid_valid_q;
          if (state_q == HOLD && (fc_if.flush || !fc_if.stall)) state_d = FETCH;
        end
      end
    endcase
  end

  // Flush beats stall; under stall a new entry parks in the skid.
  always_comb begin
    fd_d         = fd_q;
    fd_valid_d   = fd_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    if (fc_if.flush) begin
      fd_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
    end else if (fc_if.stall) begin
      if (cand_valid) begin
        skid_d       = cand;
        skid_valid_d = 1'b1;
      end else if (drop_skid) begin
        skid_valid_d = 1'b0;
      end
    end else begin
      fd_valid_d   = cand_valid;
      skid_valid_d = 1'b0;
      if (cand_valid) fd_d = cand;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC + 32'd4;
      req_q        <= RESET_PC;
      fd_q         <= '0;
      fd_valid_q   <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      fd_q         <= fd_d;
      fd_valid_q   <= fd_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule

// File: doc/tspp_fetch_stage.md
TSPP_FETCH_STAGE -- requirements
Module: tspp_fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0200, meaning the first fetch address after reset.
REQ-002 The block SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST  input  1  reset; one clock, reset synchronous and active-high.
REQ-004 The block SHALL have port fc_if  fetch_control_if.fetch modport  --  update_pc, update_addr[31:0], flush and stall, all inputs from control.
REQ-005 The block SHALL have port iaddr  output  32  instruction bus address.
REQ-006 The block SHALL have port iren  output  1  instruction bus read request.
REQ-007 The block SHALL have port ibusy  input  1  bus busy; irdata is valid in any cycle where iren=1 and ibusy=0.
REQ-008 The block SHALL have port irdata  input  32  instruction bus read data.
REQ-009 The block SHALL have port fd_valid  output  1  fetch/decode register holds a live instruction.
REQ-010 The block SHALL have ports fd_instr  output  32 and fd_pc  output  32  the fetched instruction and its address.
REQ-011 The block SHALL have port fd_misaligned  output  1  the fd entry is an instruction-address-misaligned fault.

Function
REQ-012 The block SHALL implement states FETCH, DRAIN, HOLD and FAULT, held in a registered state variable.
REQ-013 The block SHALL hold pc (next fetch address) and req_addr (address of the outstanding request); iaddr SHALL equal req_addr and stay stable while ibusy=1.
REQ-014 iren SHALL be 1 in FETCH and DRAIN and 0 in HOLD and FAULT.
REQ-015 In FETCH on completion (ibusy=0) with no update_pc/flush: if stall=0, fd <= {1, irdata, req_addr, misaligned=0}; if stall=1, the word goes to a one-entry skid buffer and the state goes to HOLD; in both cases pc and req_addr advance by 4 (32-bit wrap, carry dropped).
REQ-016 In FETCH, update_pc with ibusy=1 SHALL set pc <= update_addr, keep req_addr unchanged and go to DRAIN.
REQ-017 In FETCH, update_pc with ibusy=0 SHALL discard irdata and set pc and req_addr to update_addr.
REQ-018 DRAIN SHALL keep iren=1 at the old req_addr until ibusy=0, discard that data, then go to FETCH with req_addr <= pc; further update_pc in DRAIN SHALL only overwrite pc.
REQ-019 HOLD: when stall=0, fd <= skid, skid cleared, state -> FETCH (fd update lags stall release by 0 cycles).
REQ-020 flush SHALL clear fd_valid and the skid entry in the same edge, regardless of stall; flush SHALL take priority over stall, and update_pc SHALL take priority over stall.
REQ-021 stall=1 without flush SHALL hold fd_valid, fd_instr, fd_pc and fd_misaligned unchanged.
REQ-022 update_pc with update_addr[1:0] != 0 SHALL set pc and req_addr to update_addr; once no bus request is outstanding, the state SHALL go to FAULT, where iren=0.
REQ-023 On entry to FAULT the block SHALL load fd <= {1, 32'h0000_0013, update_addr, misaligned=1}, subject to stall and flush.
REQ-024 The block SHALL leave FAULT only on an update_pc.
REQ-025 When update_pc, flush and a bus completion coincide, the completion data SHALL be discarded.

Reset
REQ-026 While RST=1 the block SHALL set state=FETCH, pc=RESET_PC+4, req_addr=RESET_PC, fd_valid=0, fd_instr=0, fd_pc=0, fd_misaligned=0 and skid empty.
REQ-027 Reset asserted during an outstanding request SHALL abandon it; the first cycle after RST falls SHALL show iren=1 and iaddr=RESET_PC.

Structure
REQ-028 Enum fetch_state_t and the NOP encoding constant SHALL live in tspp_types_pkg, and word_t SHALL be used for every 32-bit quantity.
REQ-029 The block SHALL be one module with no sub-modules; the skid entry SHALL be in-module registers.

Verification
REQ-030 Reset release with ibusy=0 always -> iaddr 0x200, 0x204, 0x208 on consecutive cycles; fd_pc follows one cycle later with fd_valid=1.
REQ-031 ibusy=1 for 3 cycles at 0x204, then update_pc=1 and flush=1 with update_addr=0x1000 on cycle 2 -> iaddr holds 0x204 until ibusy=0, that data is never in fd, next iaddr=0x1000.
REQ-032 stall=1 as the 0x208 fetch completes, held 4 cycles -> fd stays 0x204 entry, iren=0 in HOLD; on release fd_pc=0x208 and the next fetch is 0x20C.
REQ-033 update_pc=1 with update_addr=0x1002 -> fd_valid=1, fd_misaligned=1, fd_instr=0x13 and fd_pc=0x1002, iren stays 0 until update_addr=0x2000 is given.
REQ-034 flush=1 and stall=1 together while in HOLD -> fd_valid=0 and the skid entry is dropped next cycle.
REQ-035 RST=1 mid-DRAIN -> all outputs match REQ-026 next cycle.
